// File: rtl/instr_loader.sv
// Boot-time instruction RAM loader: parses a little-endian 16-bit word count, then packs
// four stream bytes per 32-bit word and issues one single-cycle RAM write per word.
module instr_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] writeAddr,
    output logic                  we,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    // Largest word count the RAM can hold; wide RAMs are limited only by the 16-bit header.
    localparam int unsigned          CAP_WORDS = (ADDR_WIDTH >= 16) ? 65536 : (1 << ADDR_WIDTH);
    localparam logic [16:0]          MAX_WORDS = 17'(CAP_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                  r_state;
    logic [7:0]              r_countLo;
    logic [15:0]             r_wordsLeft;
    logic [1:0]              r_byteCnt;
    logic [23:0]             r_shift;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;

    logic                    w_xfer;
    logic [15:0]             w_count;

    assign byte_ready = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_LOAD);
    assign w_xfer     = byte_valid && byte_ready;
    assign w_count    = {byte_in, r_countLo};

    assign data       = r_data;
    assign writeAddr  = r_addr;
    assign we         = r_we;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_countLo   <= '0;
            r_wordsLeft <= '0;
            r_byteCnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_addr      <= BASE_ADDR;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state <= S_HDR0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                S_HDR0: begin
                    if (w_xfer) begin
                        r_countLo <= byte_in;
                        r_state   <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_xfer) begin
                        if (w_count == 16'd0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if ({1'b0, w_count} > MAX_WORDS) begin
                            r_state <= S_ERROR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_wordsLeft <= w_count;
                            r_addr      <= BASE_ADDR;
                            r_byteCnt   <= 2'd0;
                            r_state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        // The fourth byte goes straight into the output word, so no shift slot is needed for it.
                        if (r_byteCnt == 2'd3) begin
                            r_data  <= {byte_in, r_shift};
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end else begin
                            r_shift[{r_byteCnt, 3'b000} +: 8] <= byte_in;
                        end
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_we        <= 1'b0;
                    r_wordsLeft <= r_wordsLeft - 16'd1;
                    if (r_wordsLeft == 16'd1) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + ADDR_ONE;
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: two instances (base 0 and base 1022) share one byte stream
// so each test also exercises the address wrap; RAM writes are logged on the falling edge.
module tb_instr_loader;

    logic        clock = 1'b0;
    logic        resetN;
    logic        start;
    logic [7:0]  byteIn;
    logic        byteValid;

    logic        byteReady, we, busy, done, error;
    logic [31:0] ramData;
    logic [9:0]  writeAddr;

    logic        wByteReady, wWe, wBusy, wDone, wError;
    logic [31:0] wRamData;
    logic [9:0]  wWriteAddr;

    int checkCount = 0;
    int errorCount = 0;

    logic [9:0]  logAddr[$];
    logic [31:0] logData[$];
    logic [9:0]  wLogAddr[$];
    logic [31:0] wLogData[$];

    instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BASE_ADDR(10'd0)) dut (
        .CLK(clock), .RST(resetN), .start(start), .byte_in(byteIn), .byte_valid(byteValid),
        .byte_ready(byteReady), .data(ramData), .writeAddr(writeAddr), .we(we),
        .busy(busy), .done(done), .error(error)
    );

    instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BASE_ADDR(10'd1022)) dutWrap (
        .CLK(clock), .RST(resetN), .start(start), .byte_in(byteIn), .byte_valid(byteValid),
        .byte_ready(wByteReady), .data(wRamData), .writeAddr(wWriteAddr), .we(wWe),
        .busy(wBusy), .done(wDone), .error(wError)
    );

    always #5 clock = ~clock;

    // The RAM samples on the falling edge, so that is where writes are recorded.
    always @(negedge clock) begin
        if (we) begin
            logAddr.push_back(writeAddr);
            logData.push_back(ramData);
        end
        if (wWe) begin
            wLogAddr.push_back(wWriteAddr);
            wLogData.push_back(wRamData);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        logAddr.delete();
        logData.delete();
        wLogAddr.delete();
        wLogData.delete();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers one byte until it is accepted, then idles for a random gap (optionally poking start).
    task automatic applyStimulus(input logic [7:0] b, input int gapMax, input bit pokeStart);
        int waitCycles;
        int gap;
        waitCycles = 0;
        byteIn     = b;
        byteValid  = 1'b1;
        while (!byteReady && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (!byteReady) checkOutput("byteReadyTimeout", {63'd0, byteReady}, 64'd1);
        tick();
        byteValid = 1'b0;
        gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
        for (int i = 0; i < gap; i++) begin
            if (pokeStart && i == 0) pulseStart();
            else tick();
        end
    endtask

    task automatic sendWord(input logic [31:0] w, input int gapMax, input bit pokeStart);
        for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], gapMax, pokeStart);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 10 && !done; i++) tick();
    endtask

    initial begin
        resetN    = 1'b1;
        start     = 1'b0;
        byteIn    = 8'h00;
        byteValid = 1'b0;
        #2 resetN = 1'b0;
        #10;
        checkOutput("rstWe",        {63'd0, we},        64'd0);
        checkOutput("rstBusy",      {63'd0, busy},      64'd0);
        checkOutput("rstDone",      {63'd0, done},      64'd0);
        checkOutput("rstError",     {63'd0, error},     64'd0);
        checkOutput("rstByteReady", {63'd0, byteReady}, 64'd0);
        checkOutput("rstData",      {32'd0, ramData},   64'd0);
        checkOutput("rstAddr",      {54'd0, writeAddr}, 64'd0);
        checkOutput("rstAddrWrap",  {54'd0, wWriteAddr}, 64'd1022);
        @(negedge clock) resetN = 1'b1;
        tick();

        // Test 1: reset in the middle of a word aborts the load.
        $display("[TB] test 1: reset mid-load");
        clearLogs();
        pulseStart();
        applyStimulus(8'h02, 0, 1'b0);
        applyStimulus(8'h00, 0, 1'b0);
        applyStimulus(8'h55, 0, 1'b0);
        applyStimulus(8'h66, 0, 1'b0);
        checkOutput("t1BusyBefore", {63'd0, busy}, 64'd1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("t1We",        {63'd0, we},         64'd0);
        checkOutput("t1Busy",      {63'd0, busy},       64'd0);
        checkOutput("t1ByteReady", {63'd0, byteReady},  64'd0);
        checkOutput("t1Addr",      {54'd0, writeAddr},  64'd0);
        checkOutput("t1AddrWrap",  {54'd0, wWriteAddr}, 64'd1022);
        @(negedge clock) resetN = 1'b1;
        tick();
        byteIn = 8'h77;
        byteValid = 1'b1;
        repeat (6) tick();
        byteValid = 1'b0;
        checkOutput("t1IdleReady", {63'd0, byteReady}, 64'd0);
        checkOutput("t1IdleBusy",  {63'd0, busy},      64'd0);
        checkOutput("t1NoWrites",  64'(logAddr.size()), 64'd0);

        // Test 2: two-word load with little-endian packing.
        $display("[TB] test 2: two-word load");
        clearLogs();
        pulseStart();
        checkOutput("t2Busy",  {63'd0, busy},      64'd1);
        checkOutput("t2Ready", {63'd0, byteReady}, 64'd1);
        applyStimulus(8'h02, 0, 1'b0);
        applyStimulus(8'h00, 0, 1'b0);
        sendWord(32'h0000_0013, 0, 1'b0);
        checkOutput("t2FirstWe",   {63'd0, we},      64'd1);
        checkOutput("t2FirstData", {32'd0, ramData}, 64'h13);
        sendWord(32'hDEAD_BEEF, 0, 1'b0);
        checkOutput("t2LastWe",    {63'd0, we},        64'd1);
        checkOutput("t2LastData",  {32'd0, ramData},   64'hDEADBEEF);
        checkOutput("t2LastAddr",  {54'd0, writeAddr}, 64'd1);
        tick();
        checkOutput("t2WeDrop", {63'd0, we},   64'd0);
        checkOutput("t2Done",   {63'd0, done}, 64'd1);
        checkOutput("t2BusyLow", {63'd0, busy}, 64'd0);
        checkOutput("t2Writes", 64'(logAddr.size()), 64'd2);
        checkOutput("t2Addr0",  {54'd0, logAddr[0]}, 64'd0);
        checkOutput("t2Data0",  {32'd0, logData[0]}, 64'h13);
        checkOutput("t2Addr1",  {54'd0, logAddr[1]}, 64'd1);
        checkOutput("t2Data1",  {32'd0, logData[1]}, 64'hDEADBEEF);
        checkOutput("t2WrapAddr0", {54'd0, wLogAddr[0]}, 64'd1022);
        checkOutput("t2WrapAddr1", {54'd0, wLogAddr[1]}, 64'd1023);

        // Test 3: zero-length header goes straight to done.
        $display("[TB] test 3: empty load");
        clearLogs();
        pulseStart();
        checkOutput("t3DoneDrop", {63'd0, done}, 64'd0);
        applyStimulus(8'h00, 0, 1'b0);
        applyStimulus(8'h00, 0, 1'b0);
        checkOutput("t3Done", {63'd0, done}, 64'd1);
        checkOutput("t3Busy", {63'd0, busy}, 64'd0);
        repeat (3) tick();
        checkOutput("t3NoWrites", 64'(logAddr.size()), 64'd0);

        // Test 4: word count beyond RAM capacity raises error; start recovers.
        $display("[TB] test 4: oversize header");
        clearLogs();
        pulseStart();
        applyStimulus(8'h01, 0, 1'b0);
        applyStimulus(8'h04, 0, 1'b0);
        checkOutput("t4Error", {63'd0, error},     64'd1);
        checkOutput("t4Ready", {63'd0, byteReady}, 64'd0);
        checkOutput("t4Busy",  {63'd0, busy},      64'd0);
        pulseStart();
        checkOutput("t4ErrorClr", {63'd0, error},     64'd0);
        checkOutput("t4Recover",  {63'd0, byteReady}, 64'd1);

        // Test 5: exact capacity (0x0400) is legal; then a 3-word load from the recovered HDR0.
        $display("[TB] test 5: address wrap");
        applyStimulus(8'h03, 0, 1'b0);
        applyStimulus(8'h00, 0, 1'b0);
        sendWord(32'h1111_1111, 0, 1'b0);
        sendWord(32'hAABB_CCDD, 0, 1'b0);
        sendWord(32'h3333_3333, 0, 1'b0);
        waitDone();
        checkOutput("t5Done",       {63'd0, done}, 64'd1);
        checkOutput("t5Writes",     64'(wLogAddr.size()), 64'd3);
        checkOutput("t5WrapAddr0",  {54'd0, wLogAddr[0]}, 64'd1022);
        checkOutput("t5WrapAddr1",  {54'd0, wLogAddr[1]}, 64'd1023);
        checkOutput("t5WrapAddr2",  {54'd0, wLogAddr[2]}, 64'd0);
        checkOutput("t5WrapData1",  {32'd0, wLogData[1]}, 64'hAABBCCDD);
        checkOutput("t5WrapData2",  {32'd0, wLogData[2]}, 64'h33333333);
        clearLogs();
        pulseStart();
        applyStimulus(8'h00, 0, 1'b0);
        applyStimulus(8'h04, 0, 1'b0);
        checkOutput("t5CapNoError", {63'd0, error}, 64'd0);
        checkOutput("t5CapBusy",    {63'd0, busy},  64'd1);
        #2 resetN = 1'b0;
        @(negedge clock) resetN = 1'b1;
        tick();

        // Test 6: gappy stream with start pulses while busy gives the same image.
        $display("[TB] test 6: gaps and ignored start");
        clearLogs();
        pulseStart();
        applyStimulus(8'h03, 3, 1'b1);
        applyStimulus(8'h00, 3, 1'b1);
        sendWord(32'h0123_4567, 3, 1'b1);
        sendWord(32'h89AB_CDEF, 3, 1'b1);
        sendWord(32'hCAFE_F00D, 3, 1'b0);
        waitDone();
        checkOutput("t6Done",   {63'd0, done}, 64'd1);
        checkOutput("t6Writes", 64'(logAddr.size()), 64'd3);
        checkOutput("t6Addr0",  {54'd0, logAddr[0]}, 64'd0);
        checkOutput("t6Data0",  {32'd0, logData[0]}, 64'h01234567);
        checkOutput("t6Addr1",  {54'd0, logAddr[1]}, 64'd1);
        checkOutput("t6Data1",  {32'd0, logData[1]}, 64'h89ABCDEF);
        checkOutput("t6Addr2",  {54'd0, logAddr[2]}, 64'd2);
        checkOutput("t6Data2",  {32'd0, logData[2]}, 64'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
